// File: rtl/rx_pkg.sv
// Shared definitions for the data-strobe receive front end: control-code
// values, FIFO marker entries and the character framing state set.
package rx_pkg;

    // Control codes as assembled from the two control bits, bit0 first.
    localparam logic [1:0] CTL_FCT = 2'd0;
    localparam logic [1:0] CTL_EOP = 2'd1;
    localparam logic [1:0] CTL_EEP = 2'd2;
    localparam logic [1:0] CTL_ESC = 2'd3;

    // FIFO entries for packet markers; N-chars are {1'b0, data}.
    localparam logic [8:0] Q_EOP = 9'h100;
    localparam logic [8:0] Q_EEP = 9'h101;

    // Each state names the bit most recently received. DATA0..DATA7 must
    // stay contiguous: the data path steps through them by increment.
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_PAR,
        ST_FLAG,
        ST_CTL0,
        ST_CTL1,
        ST_DATA0,
        ST_DATA1,
        ST_DATA2,
        ST_DATA3,
        ST_DATA4,
        ST_DATA5,
        ST_DATA6,
        ST_DATA7,
        ST_HALT
    } rx_state_e;

endpackage

// File: rtl/rx_fifo.sv
// Synchronous FIFO with a push/full write side and a pop/valid read side.
// A push while full is accepted only when a pop happens in the same cycle;
// a pop while empty is ignored, so a push into an empty FIFO always lands.
module rx_fifo #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             full_o,
    input  logic             pop_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] q_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign valid_o = (count_q != '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign do_pop  = pop_i && valid_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign q_o     = valid_o ? mem_q[rd_ptr_q] : '0;

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage write; contents need no reset because valid_o gates the head.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/rx_char_parser.sv
// Data-strobe receive front end: recovers bits from d/s, frames characters
// LSB first, checks odd parity, detects NULL / escape errors / disconnect and
// queues N-chars plus EOP/EEP markers in a FIFO drained by valid/ready.
// Optional feature macro: RX_TIMECODE_EN adds tick/timeOut for time-codes.
module rx_char_parser
    import rx_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned DISC_CYCLES = 64,
    parameter int unsigned DISC_W      = 8
) (
    input  logic       rxClk,
    input  logic       rxReset,
    input  logic       d,
    input  logic       s,
    output logic [8:0] q,
    output logic       qValid,
    input  logic       qReady,
    output logic       fct,
    output logic       gotNull,
    output logic       parityError,
    output logic       escError,
    output logic       disconnect,
    output logic       overflow
`ifdef RX_TIMECODE_EN
    ,
    output logic       tick,
    output logic [7:0] timeOut
`endif
);

    logic [1:0]        ds_q;
    rx_state_e         state_q,    state_d;
    logic              par_q,      par_d;
    logic              flag_q,     flag_d;
    logic              ctl0_q,     ctl0_d;
    logic [6:0]        data_q,     data_d;
    logic              acc_q,      acc_d;
    logic              prev_par_q, prev_par_d;
    logic              esc_q,      esc_d;
    logic [DISC_W-1:0] disc_cnt_q, disc_cnt_d;
    logic              null_q,     null_d;
    logic              par_err_q,  par_err_d;
    logic              esc_err_q,  esc_err_d;
    logic              disc_q,     disc_d;
    logic              ovf_q,      ovf_d;
    logic              ev_push_q,  ev_push_d;
    logic              ev_fct_q,   ev_fct_d;
    logic [8:0]        ev_data_q,  ev_data_d;
    logic              fct_q;
`ifdef RX_TIMECODE_EN
    logic              ev_tick_q,  ev_tick_d;
    logic              tick_q;
    logic [7:0]        tc_q;
`endif

    logic              ds_edge;
    logic              bit_w;
    logic [1:0]        code_w;
    logic [7:0]        byte_w;
    logic              fifo_full;
    logic              fifo_valid;
    logic              fifo_pop;

    assign ds_edge  = ({d, s} != ds_q);
    assign bit_w    = d;
    assign code_w   = {bit_w, ctl0_q};
    assign byte_w   = {bit_w, data_q};
    assign fifo_pop = fifo_valid && qReady;

    // Framing, parity, escape and disconnect decisions; character-level
    // actions are registered here and applied one cycle later.
    always_comb begin
        state_d    = state_q;
        par_d      = par_q;
        flag_d     = flag_q;
        ctl0_d     = ctl0_q;
        data_d     = data_q;
        acc_d      = acc_q;
        prev_par_d = prev_par_q;
        esc_d      = esc_q;
        disc_cnt_d = disc_cnt_q;
        null_d     = null_q;
        par_err_d  = par_err_q;
        esc_err_d  = esc_err_q;
        disc_d     = disc_q;
        ev_push_d  = 1'b0;
        ev_fct_d   = 1'b0;
        ev_data_d  = '0;
`ifdef RX_TIMECODE_EN
        ev_tick_d  = 1'b0;
`endif
        ovf_d      = ovf_q | (ev_push_q & fifo_full & ~fifo_pop);

        if (state_q != ST_IDLE && state_q != ST_HALT) begin
            if (ds_edge) begin
                disc_cnt_d = '0;
            end else begin
                disc_cnt_d = disc_cnt_q + DISC_W'(1);
                if (disc_cnt_d == DISC_W'(DISC_CYCLES)) begin
                    disc_d  = 1'b1;
                    state_d = ST_HALT;
                end
            end
        end

        if (ds_edge) begin
            unique case (state_q)
                ST_IDLE, ST_CTL1, ST_DATA7: begin
                    par_d   = bit_w;
                    acc_d   = 1'b0;
                    state_d = ST_PAR;
                end
                ST_PAR: begin
                    flag_d = bit_w;
                    if ((prev_par_q ^ par_q ^ bit_w) == 1'b0) begin
                        par_err_d = 1'b1;
                        state_d   = ST_HALT;
                    end else begin
                        state_d = ST_FLAG;
                    end
                end
                ST_FLAG: begin
                    acc_d = bit_w;
                    if (flag_q) begin
                        ctl0_d  = bit_w;
                        state_d = ST_CTL0;
                    end else begin
                        data_d  = {bit_w, data_q[6:1]};
                        state_d = ST_DATA0;
                    end
                end
                ST_CTL0: begin
                    prev_par_d = acc_q ^ bit_w;
                    state_d    = ST_CTL1;
                    if (esc_q) begin
                        esc_d = 1'b0;
                        if (code_w == CTL_FCT) begin
                            null_d = 1'b1;
                        end else begin
                            esc_err_d = 1'b1;
                            state_d   = ST_HALT;
                        end
                    end else begin
                        unique case (code_w)
                            CTL_ESC: esc_d = 1'b1;
                            CTL_FCT: ev_fct_d = null_q;
                            CTL_EOP: begin
                                ev_push_d = null_q;
                                ev_data_d = Q_EOP;
                            end
                            default: begin
                                ev_push_d = null_q;
                                ev_data_d = Q_EEP;
                            end
                        endcase
                    end
                end
                ST_DATA0, ST_DATA1, ST_DATA2,
                ST_DATA3, ST_DATA4, ST_DATA5: begin
                    data_d  = {bit_w, data_q[6:1]};
                    acc_d   = acc_q ^ bit_w;
                    state_d = rx_state_e'(state_q + 4'd1);
                end
                ST_DATA6: begin
                    prev_par_d = acc_q ^ bit_w;
                    state_d    = ST_DATA7;
                    if (esc_q) begin
                        esc_d = 1'b0;
`ifdef RX_TIMECODE_EN
                        ev_tick_d = null_q;
                        ev_data_d = {1'b0, byte_w};
`endif
                    end else begin
                        ev_push_d = null_q;
                        ev_data_d = {1'b0, byte_w};
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Parser and flag registers plus the one-cycle action stage.
    always_ff @(posedge rxClk) begin
        if (rxReset) begin
            ds_q       <= 2'b00;
            state_q    <= ST_IDLE;
            par_q      <= 1'b0;
            flag_q     <= 1'b0;
            ctl0_q     <= 1'b0;
            data_q     <= '0;
            acc_q      <= 1'b0;
            prev_par_q <= 1'b0;
            esc_q      <= 1'b0;
            disc_cnt_q <= '0;
            null_q     <= 1'b0;
            par_err_q  <= 1'b0;
            esc_err_q  <= 1'b0;
            disc_q     <= 1'b0;
            ovf_q      <= 1'b0;
            ev_push_q  <= 1'b0;
            ev_fct_q   <= 1'b0;
            ev_data_q  <= '0;
            fct_q      <= 1'b0;
        end else begin
            ds_q       <= {d, s};
            state_q    <= state_d;
            par_q      <= par_d;
            flag_q     <= flag_d;
            ctl0_q     <= ctl0_d;
            data_q     <= data_d;
            acc_q      <= acc_d;
            prev_par_q <= prev_par_d;
            esc_q      <= esc_d;
            disc_cnt_q <= disc_cnt_d;
            null_q     <= null_d;
            par_err_q  <= par_err_d;
            esc_err_q  <= esc_err_d;
            disc_q     <= disc_d;
            ovf_q      <= ovf_d;
            ev_push_q  <= ev_push_d;
            ev_fct_q   <= ev_fct_d;
            ev_data_q  <= ev_data_d;
            fct_q      <= ev_fct_q;
        end
    end

`ifdef RX_TIMECODE_EN
    // Time-code delivery, aligned with the FCT pulse timing.
    always_ff @(posedge rxClk) begin
        if (rxReset) begin
            ev_tick_q <= 1'b0;
            tick_q    <= 1'b0;
            tc_q      <= '0;
        end else begin
            ev_tick_q <= ev_tick_d;
            tick_q    <= ev_tick_q;
            if (ev_tick_q) begin
                tc_q <= ev_data_q[7:0];
            end
        end
    end

    assign tick    = tick_q;
    assign timeOut = tc_q;
`endif

    rx_fifo #(
        .WIDTH(9),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_i  (rxClk),
        .rst_i  (rxReset),
        .push_i (ev_push_q),
        .data_i (ev_data_q),
        .full_o (fifo_full),
        .pop_i  (fifo_pop),
        .valid_o(fifo_valid),
        .q_o    (q)
    );

    assign qValid      = fifo_valid;
    assign fct         = fct_q;
    assign gotNull     = null_q;
    assign parityError = par_err_q;
    assign escError    = esc_err_q;
    assign disconnect  = disc_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_rx_char_parser.sv
// Bench for rx_char_parser: characters are encoded onto d/s by the bench,
// and expected FIFO entries, pulses and sticky flags come from a
// character-level model of the link rules.
module tb_rx_char_parser;
    import rx_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned DISC  = 40;
    localparam int unsigned DW    = 6;

    logic       rxClk   = 1'b0;
    logic       rxReset = 1'b1;
    logic       d       = 1'b0;
    logic       s       = 1'b0;
    logic       qReady  = 1'b0;
    logic [8:0] q;
    logic       qValid;
    logic       fct;
    logic       gotNull;
    logic       parityError;
    logic       escError;
    logic       disconnect;
    logic       overflow;
`ifdef RX_TIMECODE_EN
    logic       tick;
    logic [7:0] timeOut;
`endif

    rx_char_parser #(
        .FIFO_DEPTH (DEPTH),
        .DISC_CYCLES(DISC),
        .DISC_W     (DW)
    ) dut (
        .rxClk      (rxClk),
        .rxReset    (rxReset),
        .d          (d),
        .s          (s),
        .q          (q),
        .qValid     (qValid),
        .qReady     (qReady),
        .fct        (fct),
        .gotNull    (gotNull),
        .parityError(parityError),
        .escError   (escError),
        .disconnect (disconnect),
        .overflow   (overflow)
`ifdef RX_TIMECODE_EN
        ,
        .tick       (tick),
        .timeOut    (timeOut)
`endif
    );

    always #5 rxClk = ~rxClk;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic       cur_d, cur_s;
    bit         enc_prev_par;
    bit         gaps_en;
    bit         rnd_mode;
    bit         ready_force;
    bit         m_halt, m_gotnull, m_esc, m_parerr, m_escerr, m_ovf, m_disc;
    int         m_fct, m_tick;
    logic [7:0] m_tc;
    logic [8:0] exp_q[$];
    int         fct_seen = 0, tick_seen = 0;
    int         fct_base, tick_base;
    logic [7:0] hello [7] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h0D, 8'h0A};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_push(input logic [8:0] v);
        if (exp_q.size() >= DEPTH) m_ovf = 1'b1;
        else exp_q.push_back(v);
    endtask

    // Link rules applied per complete character.
    task automatic model_char(input bit ctl, input logic [7:0] val, input bit bad);
        if (m_halt) return;
        if (bad) begin
            m_parerr = 1'b1;
            m_halt   = 1'b1;
            return;
        end
        if (ctl) begin
            if (m_esc) begin
                m_esc = 1'b0;
                if (val[1:0] == CTL_FCT) m_gotnull = 1'b1;
                else begin
                    m_escerr = 1'b1;
                    m_halt   = 1'b1;
                end
            end else begin
                case (val[1:0])
                    CTL_ESC: m_esc = 1'b1;
                    CTL_FCT: if (m_gotnull) m_fct++;
                    CTL_EOP: if (m_gotnull) model_push(Q_EOP);
                    default: if (m_gotnull) model_push(Q_EEP);
                endcase
            end
        end else if (m_esc) begin
            m_esc = 1'b0;
`ifdef RX_TIMECODE_EN
            if (m_gotnull) begin
                m_tick++;
                m_tc = val;
            end
`endif
        end else if (m_gotnull) begin
            model_push({1'b0, val});
        end
    endtask

    task automatic send_bit(input logic b);
        int gap;
        gap = gaps_en ? int'($urandom_range(0, 2)) : 0;
        repeat (gap) @(posedge rxClk);
        @(posedge rxClk);
        #1;
        if (b != cur_d) cur_d = b;
        else cur_s = ~cur_s;
        d = cur_d;
        s = cur_s;
    endtask

    task automatic send_char(input bit ctl, input logic [7:0] val, input bit bad);
        int n;
        bit cp;
        bit p;
        n  = ctl ? 2 : 8;
        cp = 1'b0;
        for (int i = 0; i < n; i++) cp ^= val[i];
        p = 1'b1 ^ enc_prev_par ^ ctl;
        if (bad) p = ~p;
        send_bit(p);
        send_bit(ctl);
        for (int i = 0; i < n; i++) send_bit(val[i]);
        enc_prev_par = cp;
        model_char(ctl, val, bad);
    endtask

    task automatic send_ctl(input logic [1:0] c);
        send_char(1'b1, {6'd0, c}, 1'b0);
    endtask

    task automatic send_null();
        send_ctl(CTL_ESC);
        send_ctl(CTL_FCT);
    endtask

    task automatic do_reset();
        @(posedge rxClk);
        #1;
        rxReset     = 1'b1;
        d           = 1'b0;
        s           = 1'b0;
        ready_force = 1'b0;
        rnd_mode    = 1'b0;
        gaps_en     = 1'b0;
        repeat (3) @(posedge rxClk);
        #1;
        rxReset      = 1'b0;
        cur_d        = 1'b0;
        cur_s        = 1'b0;
        enc_prev_par = 1'b0;
        m_halt = 0; m_gotnull = 0; m_esc = 0; m_parerr = 0;
        m_escerr = 0; m_ovf = 0; m_disc = 0;
        m_fct = 0; m_tick = 0; m_tc = '0;
        exp_q.delete();
        fct_base  = fct_seen;
        tick_base = tick_seen;
    endtask

    task automatic check_flags();
        check_eq("gotNull", gotNull, m_gotnull);
        check_eq("parityError", parityError, m_parerr);
        check_eq("escError", escError, m_escerr);
        check_eq("disconnect", disconnect, m_disc);
        check_eq("overflow", overflow, m_ovf);
        check_eq("fct_count", fct_seen - fct_base, m_fct);
`ifdef RX_TIMECODE_EN
        check_eq("tick_count", tick_seen - tick_base, m_tick);
        check_eq("timeOut", timeOut, m_tc);
`endif
    endtask

    task automatic drain_and_check();
        rnd_mode    = 1'b0;
        ready_force = 1'b1;
        repeat (2 * DEPTH + 6) @(posedge rxClk);
        @(negedge rxClk);
        check_eq("drain_empty", exp_q.size(), 0);
        check_eq("qValid_after_drain", qValid, 1'b0);
        check_flags();
        ready_force = 1'b0;
    endtask

    task automatic monitor_loop();
        logic [8:0] e;
        forever begin
            @(negedge rxClk);
            if (!rxReset) begin
                if (fct) fct_seen++;
`ifdef RX_TIMECODE_EN
                if (tick) tick_seen++;
`endif
                if (qValid && qReady) begin
                    if (exp_q.size() == 0) begin
                        check_eq("q_unexpected_pop", exp_q.size(), 1);
                    end else begin
                        e = exp_q.pop_front();
                        check_eq("q_data", q, e);
                    end
                end
            end
        end
    endtask

    task automatic ready_loop();
        forever begin
            @(posedge rxClk);
            #1;
            if (rnd_mode) qReady = ($urandom_range(0, 3) != 0);
            else qReady = ready_force;
        end
    endtask

    task automatic watchdog();
        #3000000;
        $display("FAIL watchdog: time limit reached, %0d checks, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    endtask

    initial begin
        int r;
        fork
            monitor_loop();
            ready_loop();
            watchdog();
        join_none

        // Reset state
        do_reset();
        check_eq("rst_q", q, 9'h000);
        check_eq("rst_qValid", qValid, 1'b0);
        check_eq("rst_fct", fct, 1'b0);
        check_eq("rst_gotNull", gotNull, 1'b0);
        check_eq("rst_parityError", parityError, 1'b0);
        check_eq("rst_escError", escError, 1'b0);
        check_eq("rst_disconnect", disconnect, 1'b0);
        check_eq("rst_overflow", overflow, 1'b0);

        // ESC alone does not set gotNull; ESC,FCT does; NULLs give no fct
        send_ctl(CTL_ESC);
        repeat (2) @(posedge rxClk);
        #1 check_eq("gotNull_after_esc", gotNull, 1'b0);
        send_ctl(CTL_FCT);
        repeat (2) @(posedge rxClk);
        #1 check_eq("gotNull_after_null", gotNull, 1'b1);
        send_null();
        drain_and_check();

        // NULL,NULL then a text string streamed with qReady high
        do_reset();
        send_null();
        send_null();
        ready_force = 1'b1;
        foreach (hello[i]) send_char(1'b0, hello[i], 1'b0);
        drain_and_check();

        // FCT pulse timing, then EOP and EEP markers
        do_reset();
        ready_force = 1'b1;
        send_null();
        send_ctl(CTL_FCT);
        @(posedge rxClk);
        #1 check_eq("fct_at_N", fct, 1'b0);
        @(posedge rxClk);
        #1 check_eq("fct_at_N1", fct, 1'b1);
        @(posedge rxClk);
        #1 check_eq("fct_at_N2", fct, 1'b0);
        send_ctl(CTL_EOP);
        send_ctl(CTL_EEP);
        drain_and_check();

        // Write latency into an empty FIFO, then overflow with qReady low
        do_reset();
        send_null();
        send_char(1'b0, 8'hA5, 1'b0);
        @(posedge rxClk);
        #1 check_eq("qValid_at_N", qValid, 1'b0);
        @(posedge rxClk);
        #1 check_eq("qValid_at_N1", qValid, 1'b1);
        check_eq("q_head_at_N1", q, 9'h0A5);
        for (int i = 1; i <= DEPTH; i++) send_char(1'b0, 8'(8'h10 + i), 1'b0);
        repeat (3) @(posedge rxClk);
        #1 check_eq("overflow_set", overflow, 1'b1);
        check_eq("overflow_model", m_ovf, 1'b1);
        drain_and_check();

        // Parity error on the third character freezes parsing
        do_reset();
        send_null();
        send_char(1'b0, 8'h31, 1'b0);
        send_char(1'b0, 8'h32, 1'b0);
        send_char(1'b0, 8'h33, 1'b1);
        send_char(1'b0, 8'h34, 1'b0);
        send_ctl(CTL_EOP);
        repeat (2) @(posedge rxClk);
        #1 check_eq("parityError_set", parityError, 1'b1);
        drain_and_check();

        // ESC,ESC escape error freezes parsing
        do_reset();
        send_null();
        send_char(1'b0, 8'h5A, 1'b0);
        send_ctl(CTL_ESC);
        send_ctl(CTL_ESC);
        send_char(1'b0, 8'h66, 1'b0);
        drain_and_check();

        // Disconnect exactly DISC cycles after the last transition
        do_reset();
        send_null();
        send_char(1'b0, 8'hC3, 1'b0);
        @(posedge rxClk);
        for (int k = 1; k < DISC; k++) @(posedge rxClk);
        #1 check_eq("disc_before_limit", disconnect, 1'b0);
        @(posedge rxClk);
        #1 check_eq("disc_at_limit", disconnect, 1'b1);
        m_disc = 1'b1;
        m_halt = 1'b1;
        send_char(1'b0, 8'h77, 1'b0);
        drain_and_check();

`ifdef RX_TIMECODE_EN
        // Time-code after NULL
        do_reset();
        send_null();
        send_ctl(CTL_ESC);
        send_char(1'b0, 8'h2A, 1'b0);
        @(posedge rxClk);
        #1 check_eq("tick_at_N", tick, 1'b0);
        @(posedge rxClk);
        #1 check_eq("tick_at_N1", tick, 1'b1);
        check_eq("timeOut_at_N1", timeOut, 8'h2A);
        @(posedge rxClk);
        #1 check_eq("tick_at_N2", tick, 1'b0);
        drain_and_check();
`endif

        // Randomised traffic with random gaps and random qReady
        for (int it = 0; it < 4; it++) begin
            do_reset();
            gaps_en  = 1'b1;
            rnd_mode = 1'b1;
            if (it != 0) send_null();
            for (int c = 0; c < 40; c++) begin
                r = int'($urandom_range(0, 9));
                case (r)
                    5: send_ctl(CTL_FCT);
                    6: send_ctl(CTL_EOP);
                    7: send_ctl(CTL_EEP);
                    8: begin
                        send_ctl(CTL_ESC);
                        send_char(1'b0, 8'($urandom), 1'b0);
                    end
                    9: send_null();
                    default: send_char(1'b0, 8'($urandom), 1'b0);
                endcase
            end
            drain_and_check();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
